// File: rtl/apcm_sbc4_pkg.sv
// Shared constants, scheduler state encoding and round-robin helper for the SBC4 input path.
package apcm_sbc4_pkg;

   localparam int unsigned APCM_BLOCK_SAMPLES = 32;
   // rr_next works on a fixed-width request vector; schedulers must not exceed APCM_MAX_CH.
   localparam int unsigned APCM_MAX_CH        = 16;
   localparam int unsigned APCM_CH_W          = 4;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t StIdle   = 2'd0;
   localparam sched_state_t StSelect = 2'd1;
   localparam sched_state_t StStream = 2'd2;

   // First requester after 'last' (wrapping at n); returns 'last' when nobody requests.
   function automatic logic [APCM_CH_W-1:0] rr_next(input logic [APCM_MAX_CH-1:0] req,
                                                   input logic [APCM_CH_W-1:0]   last,
                                                   input int unsigned            n);
      logic [APCM_CH_W-1:0] win;
      logic [APCM_CH_W-1:0] idx;
      logic                 found;
      win   = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= APCM_MAX_CH; i++) begin
         idx = APCM_CH_W'((32'(last) + i) % n);
         if ((i <= n) && !found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/apcm_sbc4_ch_fifo.sv
// Per-channel synchronous FIFO with occupancy count; head word is visible combinationally.
module apcm_sbc4_ch_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_valid_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   output logic                     wr_ready_o,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   always_comb begin
      wr_ready_o = (count_q != CNT_W'(DEPTH));
      wr_en      = wr_valid_i && wr_ready_o;
      rd_en      = rd_en_i && (count_q != '0);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en) begin
         count_d = count_q + 1'b1;
      end else if (!wr_en && rd_en) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/apcm_sbc4_ch_sched.sv
// Multi-channel PCM scheduler: grants the SBC4 encoder to one channel for a whole block,
// round-robin across channels that have a full block buffered.
module apcm_sbc4_ch_sched
   import apcm_sbc4_pkg::*;
#(
   parameter int unsigned NR_CHANNELS   = 3,
   parameter int unsigned INPUT_WIDTH   = 16,
   parameter int unsigned BLOCK_SAMPLES = APCM_BLOCK_SAMPLES,
   parameter int unsigned FIFO_DEPTH    = 64,
   localparam int unsigned CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic [NR_CHANNELS*INPUT_WIDTH-1:0] s_tdata,
   input  logic [NR_CHANNELS-1:0]             s_tvalid,
   output logic [NR_CHANNELS-1:0]             s_tready,
   output logic [INPUT_WIDTH-1:0]             m_tdata,
   output logic [CHANNEL_WIDTH-1:0]           m_tid,
   output logic                               m_tvalid,
   input  logic                               m_tready,
   output logic                               m_tlast,
   output logic                               busy
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BEAT_W = (BLOCK_SAMPLES > 1) ? $clog2(BLOCK_SAMPLES) : 1;

   logic [NR_CHANNELS-1:0] blk_rdy;
   logic [NR_CHANNELS-1:0] pop;
   logic [INPUT_WIDTH-1:0] head  [NR_CHANNELS];
   logic [CNT_W-1:0]       count [NR_CHANNELS];

   for (genvar c = 0; c < NR_CHANNELS; c++) begin : gen_fifo
      apcm_sbc4_ch_fifo #(
         .WIDTH (INPUT_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .wr_valid_i (s_tvalid[c]),
         .wr_data_i  (s_tdata[c*INPUT_WIDTH +: INPUT_WIDTH]),
         .wr_ready_o (s_tready[c]),
         .rd_en_i    (pop[c]),
         .rd_data_o  (head[c]),
         .count_o    (count[c])
      );
      assign blk_rdy[c] = (count[c] >= CNT_W'(BLOCK_SAMPLES));
   end

   sched_state_t             state_q, state_d;
   logic [CHANNEL_WIDTH-1:0] grant_q, grant_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic [INPUT_WIDTH-1:0]   data_q, data_d;

   logic [APCM_MAX_CH-1:0]   req_ext;
   logic [APCM_CH_W-1:0]     rr_win;
   logic [CHANNEL_WIDTH-1:0] win_ch;
   logic [CHANNEL_WIDTH-1:0] sel_ch;
   logic [INPUT_WIDTH-1:0]   head_sel;
   logic                     pop_en;
   logic                     last_beat;

   always_comb begin
      req_ext                  = '0;
      req_ext[NR_CHANNELS-1:0] = blk_rdy;
      rr_win                   = rr_next(req_ext, APCM_CH_W'(grant_q), NR_CHANNELS);
      win_ch                   = CHANNEL_WIDTH'(rr_win);
   end

   assign last_beat = (state_q == StStream) && (beat_q == BEAT_W'(BLOCK_SAMPLES - 1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      beat_d  = beat_q;
      data_d  = data_q;
      pop_en  = 1'b0;
      sel_ch  = grant_q;
      case (state_q)
         StIdle: begin
            if (enable && (|blk_rdy)) state_d = StSelect;
         end
         StSelect: begin
            // The whole block is reserved here, so every later pop is guaranteed non-empty.
            sel_ch  = win_ch;
            grant_d = win_ch;
            beat_d  = '0;
            pop_en  = 1'b1;
            state_d = StStream;
         end
         StStream: begin
            if (m_tready) begin
               if (last_beat) begin
                  state_d = StIdle;
               end else begin
                  beat_d = beat_q + 1'b1;
                  pop_en = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      head_sel = '0;
      for (int unsigned c = 0; c < NR_CHANNELS; c++) begin
         if (sel_ch == CHANNEL_WIDTH'(c)) head_sel = head[c];
      end
      if (pop_en) data_d = head_sel;

      for (int unsigned c = 0; c < NR_CHANNELS; c++) begin
         pop[c] = pop_en && (sel_ch == CHANNEL_WIDTH'(c));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         beat_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         data_q  <= data_d;
      end
   end

   assign m_tdata  = data_q;
   assign m_tid    = grant_q;
   assign m_tvalid = (state_q == StStream);
   assign m_tlast  = last_beat;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_apcm_sbc4_ch_sched.sv
// Directed bench for apcm_sbc4_ch_sched with a scoreboard of expected output beats.
module tb_apcm_sbc4_ch_sched;

   localparam int unsigned NCH = 3;
   localparam int unsigned W   = 16;
   localparam int unsigned BS  = 32;

   logic            clk;
   logic            rst_n;
   logic            enable;
   logic [NCH*W-1:0] s_tdata;
   logic [NCH-1:0]  s_tvalid;
   logic [NCH-1:0]  s_tready;
   logic [W-1:0]    m_tdata;
   logic [1:0]      m_tid;
   logic            m_tvalid;
   logic            m_tready;
   logic            m_tlast;
   logic            busy;

   apcm_sbc4_ch_sched #(
      .NR_CHANNELS   (NCH),
      .INPUT_WIDTH   (W),
      .BLOCK_SAMPLES (BS),
      .FIFO_DEPTH    (64)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tid    (m_tid),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   tid;
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_blk(input logic [1:0] tid, input logic [W-1:0] first);
      for (int i = 0; i < int'(BS); i++) begin
         exp_q.push_back('{tid: tid, data: first + W'(i), last: (i == int'(BS) - 1)});
      end
   endtask

   // Channel c receives base + c*64 + i on write i.
   task automatic push_n(input logic [NCH-1:0] mask, input int n, input logic [W-1:0] base);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < int'(NCH); c++) begin
            s_tvalid[c] = mask[c];
            s_tdata[c*W +: W] = base + W'(c * 64 + i);
            if (mask[c]) chk("wr_ready", 32'(s_tready[c]), 32'd1);
         end
         tick();
      end
      s_tvalid = '0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         tick();
      end
      chk("drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
   endtask

   // Output monitor: scoreboard pop on handshake, stability check while stalled.
   initial begin
      logic         prev_stall;
      logic [W-1:0] prev_data;
      logic [1:0]   prev_tid;
      logic         prev_last;
      exp_t         e;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_tid   = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(m_tvalid), 32'd1);
               chk("hold_data", 32'(m_tdata), 32'(prev_data));
               chk("hold_tid", 32'(m_tid), 32'(prev_tid));
               chk("hold_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
               chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("beat_data", 32'(m_tdata), 32'(e.data));
                  chk("beat_tid", 32'(m_tid), 32'(e.tid));
                  chk("beat_last", 32'(m_tlast), 32'(e.last));
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_tid   = m_tid;
            prev_last  = m_tlast;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic r;
      rst_n    = 1'b0;
      enable   = 1'b0;
      s_tdata  = '0;
      s_tvalid = '0;
      m_tready = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tdata", 32'(m_tdata), 32'd0);
      chk("rst_tid", 32'(m_tid), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_sready", 32'(s_tready), 32'd7);

      // 1: single ramp block on ch0, with grant latency
      enable   = 1'b1;
      m_tready = 1'b1;
      exp_blk(2'd0, 16'd0);
      push_n(3'b001, 32, 16'd0);
      chk("lat0_valid", 32'(m_tvalid), 32'd0);
      chk("lat0_busy", 32'(busy), 32'd0);
      tick();
      chk("lat1_valid", 32'(m_tvalid), 32'd0);
      chk("lat1_busy", 32'(busy), 32'd1);
      tick();
      chk("lat2_valid", 32'(m_tvalid), 32'd1);
      chk("lat2_data", 32'(m_tdata), 32'd0);
      wait_idle(100);
      chk("t1_busy_low", 32'(busy), 32'd0);

      // 2: all channels ready at once, last grant 0 -> ch1, ch2, ch0
      enable = 1'b0;
      push_n(3'b111, 32, 16'h0100);
      exp_blk(2'd1, 16'h0140);
      exp_blk(2'd2, 16'h0180);
      exp_blk(2'd0, 16'h0100);
      enable = 1'b1;
      wait_idle(300);

      // 3: ready toggled every cycle
      m_tready = 1'b0;
      exp_blk(2'd0, 16'h0300);
      push_n(3'b001, 32, 16'h0300);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         m_tready = !m_tready;
         tick();
      end
      chk("t3_drain", 32'(exp_q.size() == 0 && !busy), 32'd1);
      m_tready = 1'b1;
      tick();
      tick();
      tick();
      chk("t3_no_extra", 32'(busy), 32'd0);

      // 4: fill ch0 to 64, 65th write must stall and then land in order
      enable   = 1'b0;
      m_tready = 1'b0;
      push_n(3'b001, 64, 16'h0400);
      chk("t4_full", 32'(s_tready[0]), 32'd0);
      s_tvalid[0]    = 1'b1;
      s_tdata[0 +: W] = 16'h0440;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_stall", 32'(s_tready[0]), 32'd0);
      end
      exp_blk(2'd0, 16'h0400);
      exp_blk(2'd0, 16'h0420);
      exp_blk(2'd0, 16'h0440);
      enable   = 1'b1;
      m_tready = 1'b1;
      r = 1'b0;
      for (int i = 0; i < 20; i++) begin
         r = s_tready[0];
         tick();
         if (r) break;
      end
      chk("t4_accept", 32'(r), 32'd1);
      s_tvalid = '0;
      push_n(3'b001, 31, 16'h0441);
      wait_idle(300);

      // 5: enable dropped mid-block with ch1 waiting
      exp_blk(2'd2, 16'h0580);
      push_n(3'b100, 32, 16'h0500);
      wait_idle(100);
      enable = 1'b0;
      push_n(3'b011, 32, 16'h0500);
      exp_blk(2'd0, 16'h0500);
      exp_blk(2'd1, 16'h0540);
      enable = 1'b1;
      tick();
      chk("t5_sel_busy", 32'(busy), 32'd1);
      chk("t5_sel_valid", 32'(m_tvalid), 32'd0);
      tick();
      chk("t5_first_tid", 32'(m_tid), 32'd0);
      for (int i = 0; i < 10; i++) tick();
      chk("t5_beat10", 32'(m_tdata), 32'h050A);
      enable = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         tick();
      end
      chk("t5_blk0_done", 32'(busy), 32'd0);
      chk("t5_sb_left", 32'(exp_q.size()), 32'(BS));
      for (int i = 0; i < 4; i++) begin
         chk("t5_no_grant", 32'(busy || m_tvalid), 32'd0);
         tick();
      end
      enable = 1'b1;
      tick();
      chk("t5_ch1_sel", 32'(busy && !m_tvalid), 32'd1);
      tick();
      chk("t5_ch1_valid", 32'(m_tvalid), 32'd1);
      chk("t5_ch1_tid", 32'(m_tid), 32'd1);
      wait_idle(100);

      // 6: reset at beat 16 discards the block and all buffered data
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back('{tid: 2'd0, data: 16'h0600 + W'(i), last: 1'b0});
      end
      push_n(3'b001, 32, 16'h0600);
      tick();
      tick();
      for (int i = 0; i < 16; i++) tick();
      chk("t6_beat16", 32'(m_tdata), 32'h0610);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(m_tvalid), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_sb", 32'(exp_q.size()), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      exp_blk(2'd0, 16'h0700);
      push_n(3'b001, 31, 16'h0700);
      for (int i = 0; i < 5; i++) begin
         chk("t6_quiet", 32'(busy || m_tvalid), 32'd0);
         tick();
      end
      push_n(3'b001, 1, 16'h071F);
      wait_idle(100);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
